// File: rtl/grey_pkg.sv
// -----------------------------------------------------------------------------
// grey_pkg
// Shared definitions for the grey-coded digit display path: digit geometry,
// the ten grey code points of the decimal counter, the matching 7-segment
// patterns ({g,f,e,d,c,b,a}, active-high), and the scan FSM state type.
// -----------------------------------------------------------------------------
package grey_pkg;

  localparam int NUM_DIGITS = 9;
  localparam int DIGIT_W    = 5;
  localparam int FRAME_W    = NUM_DIGITS * DIGIT_W;
  localparam int IDX_W      = 4;
  localparam int SEG_W      = 7;

  // Grey code points, one per decimal value
  localparam logic [DIGIT_W-1:0] GREY_0 = 5'b00000;
  localparam logic [DIGIT_W-1:0] GREY_1 = 5'b00001;
  localparam logic [DIGIT_W-1:0] GREY_2 = 5'b00011;
  localparam logic [DIGIT_W-1:0] GREY_3 = 5'b00010;
  localparam logic [DIGIT_W-1:0] GREY_4 = 5'b00110;
  localparam logic [DIGIT_W-1:0] GREY_5 = 5'b00100;
  localparam logic [DIGIT_W-1:0] GREY_6 = 5'b01100;
  localparam logic [DIGIT_W-1:0] GREY_7 = 5'b01000;
  localparam logic [DIGIT_W-1:0] GREY_8 = 5'b11000;
  localparam logic [DIGIT_W-1:0] GREY_9 = 5'b10000;

  // Segment patterns
  localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'h00;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  // Decimal point marks the thousands and millions group boundaries
  function automatic logic dp_for_digit(input logic [IDX_W-1:0] idx);
    if (idx == 4'd3 || idx == 4'd6) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

  // Digit index advance with wrap from the top digit back to the ones digit
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == 4'(NUM_DIGITS - 1)) begin
      return 4'd0;
    end else begin
      return idx + 4'd1;
    end
  endfunction

endpackage

// File: rtl/grey_seg_decode.sv
// -----------------------------------------------------------------------------
// grey_seg_decode
// Combinational translation of one 5-bit grey digit code into a 7-segment
// pattern. Codes outside the ten legal points show a dash and drop valid_o.
// Ports:
//   code_i   in  5  grey digit code
//   valid_o  out 1  code is one of the ten legal points
//   seg_o    out 7  segments {g,f,e,d,c,b,a}, active-high
// -----------------------------------------------------------------------------
module grey_seg_decode
  import grey_pkg::*;
(
  input  logic [DIGIT_W-1:0] code_i,
  output logic               valid_o,
  output logic [SEG_W-1:0]   seg_o
);

  // Code lookup; anything unrecognised falls to the dash pattern
  always_comb begin
    valid_o = 1'b1;
    seg_o   = SEG_DASH;
    case (code_i)
      GREY_0:  seg_o = SEG_0;
      GREY_1:  seg_o = SEG_1;
      GREY_2:  seg_o = SEG_2;
      GREY_3:  seg_o = SEG_3;
      GREY_4:  seg_o = SEG_4;
      GREY_5:  seg_o = SEG_5;
      GREY_6:  seg_o = SEG_6;
      GREY_7:  seg_o = SEG_7;
      GREY_8:  seg_o = SEG_8;
      GREY_9:  seg_o = SEG_9;
      default: begin
        valid_o = 1'b0;
        seg_o   = SEG_DASH;
      end
    endcase
  end

endmodule

// File: rtl/grey_scan_display.sv
// -----------------------------------------------------------------------------
// grey_scan_display
// Display stage for the 9-digit grey-coded decimal counter. Once per frame it
// snapshots the digit bus, then scans the digits one at a time onto a single
// 7-segment bus with a one-hot strobe, separated by all-off dead time.
// Invalid digit codes show a dash and set a sticky error flag.
//
// Parameters:
//   PRESCALE      cycles each digit is driven (>=2)
//   BLANK_CYCLES  all-strobes-off cycles between digits (>=1)
// Ports:
//   i_clk      in   1   clock
//   i_rst      in   1   synchronous reset, active-high
//   i_digits   in   45  9 x 5-bit grey digits, [4:0]=ones .. [44:40]=1e8
//   o_dig_sel  out  9   one-hot digit strobe, zero during blank
//   o_seg      out  7   segments {g,f,e,d,c,b,a}, active-high
//   o_dp       out  1   thousands separator
//   o_frame    out  1   pulse on the first cycle of a new snapshot
//   o_err      out  1   sticky invalid-code flag
// Build option:
//   GREY_SCAN_LZB_EN  leading-zero blanking of the snapshot (digit 0 never
//                     blanked, invalid codes count as non-zero)
// -----------------------------------------------------------------------------
module grey_scan_display
  import grey_pkg::*;
#(
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [FRAME_W-1:0]    i_digits,
  output logic [NUM_DIGITS-1:0] o_dig_sel,
  output logic [SEG_W-1:0]      o_seg,
  output logic                  o_dp,
  output logic                  o_frame,
  output logic                  o_err
);

  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]      SHOW_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_DIGITS-1:0] SEL_NONE   = {NUM_DIGITS{1'b0}};
  localparam logic [NUM_DIGITS-1:0] SEL_ONE    = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [FRAME_W-1:0]      frame_q, frame_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic [SEG_W-1:0]        seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_pulse_q, frame_pulse_d;
  logic                    err_q, err_d;

  // The digit shown next comes from the live bus only on the snapshot edge
  // (entering digit 0); every other digit reads the held snapshot, so a frame
  // is always self-consistent.
  logic [FRAME_W-1:0]      src_frame_s;
  logic [DIGIT_W-1:0]      src_digit_s [NUM_DIGITS];
  logic [DIGIT_W-1:0]      cur_code_s;
  logic                    dec_valid_s;
  logic [SEG_W-1:0]        dec_seg_s;
  logic                    lz_blank_s;

  // Source selection and per-digit split of the frame
  always_comb begin
    if (idx_q == 4'd0) begin
      src_frame_s = i_digits;
    end else begin
      src_frame_s = frame_q;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      src_digit_s[i] = src_frame_s[i*DIGIT_W +: DIGIT_W];
    end
    cur_code_s = src_digit_s[idx_q];
  end

  grey_seg_decode u_decode (
    .code_i  (cur_code_s),
    .valid_o (dec_valid_s),
    .seg_o   (dec_seg_s)
  );

`ifdef GREY_SCAN_LZB_EN
  // Bit n set when digit n and everything above it are zero; digit 0 is
  // always displayed so an all-zero value still reads "0".
  function automatic logic [NUM_DIGITS-1:0] lzb_mask(input logic [FRAME_W-1:0] f);
    logic                  seen;
    logic [NUM_DIGITS-1:0] mask;
    seen = 1'b0;
    mask = SEL_NONE;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (f[i*DIGIT_W +: DIGIT_W] != GREY_0) begin
        seen = 1'b1;
      end else begin
        seen = seen;
      end
      mask[i] = ~seen;
    end
    return mask;
  endfunction

  logic [NUM_DIGITS-1:0] lzb_mask_s;

  // Leading-zero mask of the frame the current digit belongs to
  always_comb begin
    lzb_mask_s = lzb_mask(src_frame_s);
    lz_blank_s = lzb_mask_s[idx_q];
  end
`else
  assign lz_blank_s = 1'b0;
`endif

  // Scan FSM next state; output registers are loaded on the edge that enters
  // each phase so they are stable for the whole phase.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    frame_d       = frame_q;
    sel_d         = sel_q;
    seg_d         = seg_q;
    dp_d          = dp_q;
    frame_pulse_d = 1'b0;
    err_d         = err_q;
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = CNT_ZERO;
          sel_d   = SEL_ONE << idx_q;
          if (lz_blank_s) begin
            seg_d = SEG_OFF;
            dp_d  = 1'b0;
          end else begin
            seg_d = dec_seg_s;
            dp_d  = dp_for_digit(idx_q);
          end
          if (!dec_valid_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (idx_q == 4'd0) begin
            frame_d       = i_digits;
            frame_pulse_d = 1'b1;
          end else begin
            frame_d       = frame_q;
            frame_pulse_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = BLANK;
          cnt_d   = CNT_ZERO;
          idx_d   = next_idx(idx_q);
          sel_d   = SEL_NONE;
          seg_d   = SEG_OFF;
          dp_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = CNT_ZERO;
        idx_d   = 4'd0;
        sel_d   = SEL_NONE;
        seg_d   = SEG_OFF;
        dp_d    = 1'b0;
      end
    endcase
  end

  // State, counters, snapshot and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= BLANK;
      cnt_q         <= CNT_ZERO;
      idx_q         <= 4'd0;
      frame_q       <= {FRAME_W{1'b0}};
      sel_q         <= SEL_NONE;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b0;
      frame_pulse_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      frame_q       <= frame_d;
      sel_q         <= sel_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_pulse_q <= frame_pulse_d;
      err_q         <= err_d;
    end
  end

  assign o_dig_sel = sel_q;
  assign o_seg     = seg_q;
  assign o_dp      = dp_q;
  assign o_frame   = frame_pulse_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_grey_scan_display.sv
// -----------------------------------------------------------------------------
// tb_grey_scan_display
// Scoreboard bench for grey_scan_display (PRESCALE=4, BLANK_CYCLES=2).
// The stimulus side writes a frame value just before each snapshot edge and
// queues the nine expected digit presentations (cycle, strobe, segments, dp,
// frame pulse, error flag) from a decimal/grey lookup model. A monitor pops
// one entry each time a strobe rises and also polices the blank gaps.
// Honours GREY_SCAN_LZB_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_grey_scan_display;

  localparam int P      = 4;
  localparam int B      = 2;
  localparam int DSTEP  = P + B;
  localparam int FRAMEC = 9 * DSTEP;

  localparam logic [4:0] GREY_T [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110,
                                          5'b00100, 5'b01100, 5'b01000, 5'b11000, 5'b10000};
  localparam logic [6:0] SEG_T  [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [44:0] i_digits = 45'd0;
  logic [8:0]  o_dig_sel;
  logic [6:0]  o_seg;
  logic        o_dp, o_frame, o_err;

  grey_scan_display #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_digits(i_digits),
    .o_dig_sel(o_dig_sel), .o_seg(o_seg), .o_dp(o_dp),
    .o_frame(o_frame), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [8:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic       frm;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] bad_codes[$];
  logic       err_model = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic logic [7:0] ref_decode(input logic [4:0] c);
    for (int v = 0; v < 10; v++) begin
      if (GREY_T[v] == c) return {1'b1, SEG_T[v]};
    end
    return {1'b0, 7'h40};
  endfunction

  // Decimal number -> 9 grey digits, ones first
  function automatic logic [44:0] enc(input int unsigned num);
    logic [44:0] f;
    int unsigned r;
    r = num;
    f = 45'd0;
    for (int n = 0; n < 9; n++) begin
      f[n*5 +: 5] = GREY_T[r % 10];
      r = r / 10;
    end
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_sel"},   {23'd0, o_dig_sel}, 32'd0);
    chk({tag, "_seg"},   {25'd0, o_seg},     32'd0);
    chk({tag, "_dp"},    {31'd0, o_dp},      32'd0);
    chk({tag, "_frame"}, {31'd0, o_frame},   32'd0);
    chk({tag, "_err"},   {31'd0, o_err},     32'd0);
  endtask

  // Queue expectations for the first ndig digits of frame f; the snapshot
  // edge is the next posedge.
  task automatic push_frame(input logic [44:0] f, input int ndig);
    int         msd;
    int         base;
    logic [7:0] d;
    logic       blank;
    exp_t       e;
    msd  = 0;
    base = cyc + 1;
    for (int n = 0; n < 9; n++) if (f[n*5 +: 5] != 5'd0) msd = n;
    for (int n = 0; n < ndig; n++) begin
      d = ref_decode(f[n*5 +: 5]);
`ifdef GREY_SCAN_LZB_EN
      blank = (n > msd);
`else
      blank = 1'b0;
`endif
      err_model = err_model | ~d[7];
      e.cyc = base + n * DSTEP;
      e.sel = 9'd1 << n;
      e.seg = blank ? 7'h00 : d[6:0];
      e.dp  = !blank && (n == 3 || n == 6);
      e.frm = (n == 0);
      e.err = err_model;
      exp_q.push_back(e);
    end
  endtask

  // Present frame f at the snapshot, scramble the bus mid-frame, and
  // optionally hit reset at negedge reset_at (digit 5 is on screen at 31).
  task automatic run_frame(input logic [44:0] f, input int reset_at);
    int          len;
    int          junk_t;
    logic [63:0] tmp;
    i_digits = f;
    len      = (reset_at < 0) ? FRAMEC : reset_at;
    push_frame(f, (reset_at < 0) ? 9 : (reset_at - 1) / DSTEP + 1);
    junk_t = $urandom_range(1, len - 2);
    for (int t = 1; t <= len; t++) begin
      @(negedge clk);
      if (t == junk_t) begin
        tmp      = {$urandom, $urandom};
        i_digits = tmp[44:0];
      end
    end
    if (reset_at >= 0) begin
      i_rst = 1'b1;
      @(posedge clk);
      #1;
      chk_zero_outputs("midrst");
      err_model = 1'b0;
      @(negedge clk);
      i_rst = 1'b0;
      repeat (B - 1) @(negedge clk);
    end
  endtask

  function automatic logic [44:0] rand_frame();
    logic [44:0] f;
    f = enc($urandom_range(0, 999999999) >> $urandom_range(0, 29));
    if ($urandom_range(0, 3) == 0) begin
      f[$urandom_range(0, 8)*5 +: 5] = bad_codes[$urandom_range(0, bad_codes.size() - 1)];
    end
    return f;
  endfunction

  // Monitor: one scoreboard entry per rising strobe, blank gaps must be dark
  initial begin : monitor
    logic [8:0] prev_sel;
    logic       start;
    exp_t       e;
    prev_sel = 9'd0;
    forever begin
      @(posedge clk);
      #1;
      start = (o_dig_sel != 9'd0) && (prev_sel == 9'd0);
      if (start) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe: got sel %0h expected none (cycle %0d)", o_dig_sel, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("strobe_sel", {23'd0, o_dig_sel}, {23'd0, e.sel});
          chk("seg", {25'd0, o_seg}, {25'd0, e.seg});
          chk("dp", {31'd0, o_dp}, {31'd0, e.dp});
          chk("frame_pulse", {31'd0, o_frame}, {31'd0, e.frm});
          chk("err", {31'd0, o_err}, {31'd0, e.err});
        end
      end else begin
        chk("stray_frame", {31'd0, o_frame}, 32'd0);
        if (o_dig_sel == 9'd0) chk("blank_dark", {24'd0, o_seg, o_dp}, 32'd0);
      end
      prev_sel = o_dig_sel;
    end
  end

  // Stimulus
  initial begin : stim
    logic [44:0] f;
    for (int c = 0; c < 32; c++) begin
      if (ref_decode(5'(c)) == {1'b0, 7'h40}) bad_codes.push_back(5'(c));
    end
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    i_rst = 1'b0;
    repeat (B - 1) @(negedge clk);

    run_frame(enc(0), -1);
    run_frame(enc(123456789), -1);
    run_frame(enc(1200), -1);
    f = enc($urandom_range(0, 999999999));
    f[9:5] = 5'b10101;
    run_frame(f, -1);
    for (int k = 0; k < 5; k++) run_frame(rand_frame(), -1);
    run_frame(rand_frame(), 5 * DSTEP + 1);
    run_frame(enc(0), -1);
    for (int k = 0; k < 4; k++) run_frame(rand_frame(), -1);

    i_rst = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
